// File: rtl/event_stream_mux_if.sv
// rtl/event_stream_mux_if.sv - AXI-Stream bundle for the data/event/output links of event_stream_mux
// Ports (signals):
//   AXIS_DATA_*  bulk data stream (TDATA 256, TVALID, TLAST, TREADY)
//   AXIS_EVT_*   single-beat event stream (TDATA 256, TVALID, TREADY)
//   AXIS_OUT_*   merged output stream (TDATA 256, TVALID, TLAST, TREADY)
// Modports: slave = mux side, master = environment side.
interface event_stream_mux_if;
    logic [255:0] AXIS_DATA_TDATA;
    logic         AXIS_DATA_TVALID;
    logic         AXIS_DATA_TLAST;
    logic         AXIS_DATA_TREADY;
    logic [255:0] AXIS_EVT_TDATA;
    logic         AXIS_EVT_TVALID;
    logic         AXIS_EVT_TREADY;
    logic [255:0] AXIS_OUT_TDATA;
    logic         AXIS_OUT_TVALID;
    logic         AXIS_OUT_TLAST;
    logic         AXIS_OUT_TREADY;

    modport slave (
        input  AXIS_DATA_TDATA, AXIS_DATA_TVALID, AXIS_DATA_TLAST,
        output AXIS_DATA_TREADY,
        input  AXIS_EVT_TDATA, AXIS_EVT_TVALID,
        output AXIS_EVT_TREADY,
        output AXIS_OUT_TDATA, AXIS_OUT_TVALID, AXIS_OUT_TLAST,
        input  AXIS_OUT_TREADY
    );

    modport master (
        output AXIS_DATA_TDATA, AXIS_DATA_TVALID, AXIS_DATA_TLAST,
        input  AXIS_DATA_TREADY,
        output AXIS_EVT_TDATA, AXIS_EVT_TVALID,
        input  AXIS_EVT_TREADY,
        input  AXIS_OUT_TDATA, AXIS_OUT_TVALID, AXIS_OUT_TLAST,
        output AXIS_OUT_TREADY
    );
endinterface

// File: rtl/event_stream_mux.sv
// rtl/event_stream_mux.sv - merges a data stream and an event stream onto one registered AXI-Stream link
// Parameters:
//   MAX_EVT_BURST  consecutive event beats allowed while data is pending (1..15)
// Ports:
//   clk            clock, rising edge
//   resetn         synchronous active-low reset
//   axis           event_stream_mux_if.slave: data in, event in, merged out
//   evt_forwarded  32-bit wrapping count of accepted event beats
module event_stream_mux #(
    parameter int MAX_EVT_BURST = 4
) (
    input  logic                      clk,
    input  logic                      resetn,
    event_stream_mux_if.slave         axis,
    output logic [31:0]               evt_forwarded
);

    localparam logic [3:0] MAX_RUN = 4'(MAX_EVT_BURST);

    logic [255:0] out_tdata_q, out_tdata_d;
    logic         out_tvalid_q, out_tvalid_d;
    logic         out_tlast_q, out_tlast_d;
    logic         lock_q, lock_d;
    logic [3:0]   evt_run_q, evt_run_d;
    logic [31:0]  evt_forwarded_q, evt_forwarded_d;

    logic load;
    logic sel_evt;
    logic sel_data;
    logic evt_tready;
    logic data_tready;
    logic evt_xfer;
    logic data_xfer;

    always_comb begin
        load     = ~out_tvalid_q | axis.AXIS_OUT_TREADY;
        sel_evt  = 1'b0;
        sel_data = 1'b0;

        // Inside a data packet only data may proceed; otherwise events win
        // unless they have used up their burst allowance while data waits.
        if (lock_q) begin
            sel_data = axis.AXIS_DATA_TVALID;
        end else if (axis.AXIS_EVT_TVALID &&
                     ((evt_run_q < MAX_RUN) || !axis.AXIS_DATA_TVALID)) begin
            sel_evt = 1'b1;
        end else if (axis.AXIS_DATA_TVALID) begin
            sel_data = 1'b1;
        end

        evt_tready  = resetn & load & sel_evt;
        data_tready = resetn & load & sel_data;
        evt_xfer    = axis.AXIS_EVT_TVALID & evt_tready;
        data_xfer   = axis.AXIS_DATA_TVALID & data_tready;

        out_tdata_d     = out_tdata_q;
        out_tvalid_d    = out_tvalid_q;
        out_tlast_d     = out_tlast_q;
        lock_d          = lock_q;
        evt_run_d       = evt_run_q;
        evt_forwarded_d = evt_forwarded_q;

        if (load) begin
            if (evt_xfer) begin
                out_tdata_d  = axis.AXIS_EVT_TDATA;
                out_tlast_d  = 1'b1;
                out_tvalid_d = 1'b1;
            end else if (data_xfer) begin
                out_tdata_d  = axis.AXIS_DATA_TDATA;
                out_tlast_d  = axis.AXIS_DATA_TLAST;
                out_tvalid_d = 1'b1;
            end else begin
                out_tvalid_d = 1'b0;
            end
        end

        if (data_xfer) begin
            lock_d = ~axis.AXIS_DATA_TLAST;
            // First beat of a packet restores the event burst allowance.
            if (!lock_q) begin
                evt_run_d = 4'd0;
            end
        end

        if (evt_xfer) begin
            evt_forwarded_d = evt_forwarded_q + 32'd1;
            if (evt_run_q < MAX_RUN) begin
                evt_run_d = evt_run_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_tdata_q     <= '0;
            out_tvalid_q    <= 1'b0;
            out_tlast_q     <= 1'b0;
            lock_q          <= 1'b0;
            evt_run_q       <= 4'd0;
            evt_forwarded_q <= 32'd0;
        end else begin
            out_tdata_q     <= out_tdata_d;
            out_tvalid_q    <= out_tvalid_d;
            out_tlast_q     <= out_tlast_d;
            lock_q          <= lock_d;
            evt_run_q       <= evt_run_d;
            evt_forwarded_q <= evt_forwarded_d;
        end
    end

    assign axis.AXIS_EVT_TREADY  = evt_tready;
    assign axis.AXIS_DATA_TREADY = data_tready;
    assign axis.AXIS_OUT_TDATA   = out_tdata_q;
    assign axis.AXIS_OUT_TVALID  = out_tvalid_q;
    assign axis.AXIS_OUT_TLAST   = out_tlast_q;
    assign evt_forwarded         = evt_forwarded_q;

endmodule

// File: tb/tb_event_stream_mux.sv
// tb/tb_event_stream_mux.sv - directed self-checking bench for event_stream_mux
module tb_event_stream_mux;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] evt_forwarded;

    event_stream_mux_if bus();

    event_stream_mux #(.MAX_EVT_BURST(4)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .axis          (bus),
        .evt_forwarded (evt_forwarded)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [257:0] got, input logic [257:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Source queues: data entries are {tlast, tdata}, event entries are tdata.
    logic [256:0] dq[$];
    logic [255:0] eq[$];
    logic [256:0] obs[$];
    int           obs_cyc[$];
    int           cyc = 0;
    int           d_pops = 0;
    bit           d_fire = 0, e_fire = 0;
    bit           rnd_rdy = 0;
    bit           stall_prev = 0;
    logic [256:0] prev_beat = '0;

    function automatic logic [255:0] evp(input int i);
        logic [31:0] w;
        w = 32'hE000_0000 | 32'(i);
        return {8{w}};
    endfunction

    function automatic logic [256:0] dbt(input int i, input logic last);
        logic [31:0] w;
        w = 32'hD000_0000 | 32'(i);
        return {last, {8{w}}};
    endfunction

    task automatic drive_sources();
        if (dq.size() > 0) begin
            bus.AXIS_DATA_TVALID = 1'b1;
            {bus.AXIS_DATA_TLAST, bus.AXIS_DATA_TDATA} = dq[0];
        end else begin
            bus.AXIS_DATA_TVALID = 1'b0;
        end
        if (eq.size() > 0) begin
            bus.AXIS_EVT_TVALID = 1'b1;
            bus.AXIS_EVT_TDATA  = eq[0];
        end else begin
            bus.AXIS_EVT_TVALID = 1'b0;
        end
        bus.AXIS_OUT_TREADY = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    // Monitor: sample half a cycle away from the active edge.
    always @(negedge clk) begin
        if (resetn && stall_prev)
            chk("stall_hold", {bus.AXIS_OUT_TVALID, bus.AXIS_OUT_TLAST, bus.AXIS_OUT_TDATA},
                {1'b1, prev_beat});
        stall_prev = resetn && bus.AXIS_OUT_TVALID && !bus.AXIS_OUT_TREADY;
        prev_beat  = {bus.AXIS_OUT_TLAST, bus.AXIS_OUT_TDATA};
        if (resetn && bus.AXIS_OUT_TVALID && bus.AXIS_OUT_TREADY) begin
            obs.push_back({bus.AXIS_OUT_TLAST, bus.AXIS_OUT_TDATA});
            obs_cyc.push_back(cyc);
        end
        d_fire = resetn && bus.AXIS_DATA_TVALID && bus.AXIS_DATA_TREADY;
        e_fire = resetn && bus.AXIS_EVT_TVALID && bus.AXIS_EVT_TREADY;
    end

    // Source driver: retire accepted beats and present the next ones.
    always @(posedge clk) begin
        logic [256:0] tmp_d;
        logic [255:0] tmp_e;
        cyc++;
        #1;
        if (d_fire && dq.size() > 0) begin
            tmp_d = dq.pop_front();
            d_pops++;
        end
        if (e_fire && eq.size() > 0) tmp_e = eq.pop_front();
        d_fire = 0;
        e_fire = 0;
        drive_sources();
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        rnd_rdy = 0;
        dq.delete();
        eq.delete();
        tick();
        tick();
        obs.delete();
        obs_cyc.delete();
        d_pops = 0;
    endtask

    task automatic wait_obs(input string tag, input int n);
        int budget;
        budget = 400;
        while (obs.size() < n && budget > 0) begin
            tick();
            budget--;
        end
        chk(tag, 258'(obs.size()), 258'(n));
    endtask

    task automatic cmp_obs(input string tag, input logic [256:0] exp[$]);
        for (int i = 0; i < exp.size(); i++) begin
            if (i < obs.size()) chk(tag, {1'b0, obs[i]}, {1'b0, exp[i]});
        end
    endtask

    initial begin
        logic [256:0] exp[$];
        logic [255:0] sent_e[$];
        logic [256:0] sent_d[$];
        int ei, di;
        bit in_pkt;

        bus.AXIS_OUT_TREADY = 1'b1;
        drive_sources();

        // Reset with both sources valid
        do_reset();
        eq.push_back(evp(1));
        dq.push_back(dbt(1, 1'b1));
        tick();
        chk("rst_evt_tready", 258'(bus.AXIS_EVT_TREADY), 258'(0));
        chk("rst_data_tready", 258'(bus.AXIS_DATA_TREADY), 258'(0));
        chk("rst_out_tvalid", 258'(bus.AXIS_OUT_TVALID), 258'(0));
        chk("rst_out_tdata", 258'(bus.AXIS_OUT_TDATA), 258'(0));
        chk("rst_evt_fwd", 258'(evt_forwarded), 258'(0));
        resetn = 1'b1;
        tick();
        chk("rst_first_beat", {bus.AXIS_OUT_TVALID, bus.AXIS_OUT_TLAST, bus.AXIS_OUT_TDATA},
            {2'b11, evp(1)});
        wait_obs("rst_count", 2);
        exp = '{{1'b1, evp(1)}, dbt(1, 1'b1)};
        cmp_obs("rst_order", exp);
        chk("rst_evt_fwd_after", 258'(evt_forwarded), 258'(1));

        // No split: event raised mid-packet waits for TLAST
        do_reset();
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) dq.push_back(dbt(i, 1'(i == 3)));
        while (d_pops < 2) tick();
        eq.push_back(evp(0));
        tick();
        chk("nosplit_evt_held", 258'({bus.AXIS_EVT_TVALID, bus.AXIS_EVT_TREADY}), 258'(2'b10));
        wait_obs("nosplit_count", 5);
        exp = '{dbt(0, 1'b0), dbt(1, 1'b0), dbt(2, 1'b0), dbt(3, 1'b1), {1'b1, evp(0)}};
        cmp_obs("nosplit_order", exp);

        // Starvation guard: 4 events, the 2-beat packet, then 4 more events
        do_reset();
        for (int i = 0; i < 8; i++) eq.push_back(evp(i));
        dq.push_back(dbt(0, 1'b0));
        dq.push_back(dbt(1, 1'b1));
        resetn = 1'b1;
        wait_obs("starve_count", 10);
        exp.delete();
        for (int i = 0; i < 4; i++) exp.push_back({1'b1, evp(i)});
        exp.push_back(dbt(0, 1'b0));
        exp.push_back(dbt(1, 1'b1));
        for (int i = 4; i < 8; i++) exp.push_back({1'b1, evp(i)});
        cmp_obs("starve_order", exp);
        chk("starve_no_bubble", 258'(obs_cyc[9] - obs_cyc[0]), 258'(9));
        chk("starve_evt_fwd", 258'(evt_forwarded), 258'(8));

        // Simultaneous start with evt_run = 0
        do_reset();
        eq.push_back(evp(7));
        dq.push_back(dbt(7, 1'b1));
        resetn = 1'b1;
        wait_obs("simul_count", 2);
        exp = '{{1'b1, evp(7)}, dbt(7, 1'b1)};
        cmp_obs("simul_order", exp);
        chk("simul_consecutive", 258'(obs_cyc[1] - obs_cyc[0]), 258'(1));
        chk("simul_evt_run", 258'(dut.evt_run_q), 258'(0));
        chk("simul_lock", 258'(dut.lock_q), 258'(0));

        // Backpressure with mixed traffic
        do_reset();
        sent_e.delete();
        sent_d.delete();
        for (int i = 0; i < 10; i++) begin
            eq.push_back(evp(16 + i));
            sent_e.push_back(evp(16 + i));
        end
        for (int p = 0; p < 3; p++)
            for (int b = 0; b < 3; b++) begin
                dq.push_back(dbt(16 + p * 3 + b, 1'(b == 2)));
                sent_d.push_back(dbt(16 + p * 3 + b, 1'(b == 2)));
            end
        resetn = 1'b1;
        rnd_rdy = 1;
        wait_obs("bp_count", 19);
        rnd_rdy = 0;
        ei = 0;
        di = 0;
        in_pkt = 0;
        for (int i = 0; i < obs.size(); i++) begin
            if (obs[i][255:252] == 4'hE) begin
                if (in_pkt) chk("bp_pkt_split", 258'(1), 258'(0));
                if (ei < sent_e.size()) chk("bp_evt", {1'b0, obs[i]}, {2'b01, sent_e[ei]});
                ei++;
            end else begin
                if (di < sent_d.size()) chk("bp_data", {1'b0, obs[i]}, {1'b0, sent_d[di]});
                in_pkt = !obs[i][256];
                di++;
            end
        end
        chk("bp_evt_total", 258'(ei), 258'(10));
        chk("bp_data_total", 258'(di), 258'(9));

        // Counter wrap
        do_reset();
        resetn = 1'b1;
        tick();
        force dut.evt_forwarded_q = 32'hFFFF_FFFE;
        tick();
        release dut.evt_forwarded_q;
        tick();
        chk("wrap_preload", 258'(evt_forwarded), 258'(32'hFFFF_FFFE));
        for (int i = 0; i < 3; i++) eq.push_back(evp(40 + i));
        wait_obs("wrap_count", 3);
        tick();
        chk("wrap_value", 258'(evt_forwarded), 258'(32'h0000_0001));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/event_stream_mux.md
# event_stream_mux

Shares one 256-bit AXI-Stream output link between the bulk data stream and the single-beat event stream produced by the event reporter. Event beats get priority, but only at data-packet boundaries; a data packet is never split. A configurable burst limit ensures a continuous event flood cannot starve pending data. The output is fully registered, with 1-cycle latency and 1 beat/cycle throughput.

## Interface
- MAX_EVT_BURST, default 4: maximum consecutive event beats sent while a data packet is pending (legal range 1..15).
- clk  input  1  clock; all logic on the rising edge.
- resetn  input  1  reset, synchronous, active-low.
- AXIS_DATA_TDATA  input  256  data-stream payload.
- AXIS_DATA_TVALID  input  1  data-stream valid.
- AXIS_DATA_TLAST  input  1  marks the last beat of a data packet.
- AXIS_DATA_TREADY  output  1  data-stream ready (combinational).
- AXIS_EVT_TDATA  input  256  event beat payload; each event is a one-beat packet.
- AXIS_EVT_TVALID  input  1  event valid.
- AXIS_EVT_TREADY  output  1  event ready (combinational).
- AXIS_OUT_TDATA  output  256  merged payload (registered).
- AXIS_OUT_TVALID  output  1  merged valid (registered).
- AXIS_OUT_TLAST  output  1  merged last (registered); always 1 on event beats.
- AXIS_OUT_TREADY  input  1  downstream ready.
- evt_forwarded  output  32  count of event beats accepted; wraps modulo 2^32.

## Operation
Internal signals:
- **load** = ~AXIS_OUT_TVALID | AXIS_OUT_TREADY. The output register may take a new beat this cycle.
- **lock**: 1 from acceptance of a data beat with TLAST=0 until acceptance of a data beat with TLAST=1.
- **evt_run**: 4-bit counter of consecutive events, saturating at MAX_EVT_BURST.

Source selection, evaluated every cycle:
- If lock=1: select data only. Events wait even if valid.
- Else, if AXIS_EVT_TVALID and (evt_run < MAX_EVT_BURST or ~AXIS_DATA_TVALID): select event.
- Else, if AXIS_DATA_TVALID: select data.
- Else: select none.

Ready outputs:
- AXIS_EVT_TREADY = load & sel_evt.
- AXIS_DATA_TREADY = load & sel_data.
- Both are 0 while resetn=0.
- A transfer on a source is TVALID & TREADY of that source.

Output register update, on load:
- Event transfer: TDATA ← EVT_TDATA, TLAST ← 1, TVALID ← 1.
- Data transfer: TDATA ← DATA_TDATA, TLAST ← DATA_TLAST, TVALID ← 1.
- No transfer: TVALID ← 0; TDATA and TLAST hold.
- When load=0, all output registers hold.

evt_run:
- +1 on each event transfer, saturating at MAX_EVT_BURST.
- Cleared to 0 on the first beat of a data packet, i.e. a data transfer while lock=0.
- Otherwise holds, including while no events are pending.

evt_forwarded: +1 on each event transfer; wraps from 0xFFFFFFFF to 0.

Boundary conditions:
- Event and data start valid in the same cycle with evt_run < MAX: the event wins.
- evt_run = MAX and data pending: data wins. evt_run is then cleared, so events win again after that packet.
- evt_run = MAX and no data pending: events continue to flow; the counter stays saturated.
- Single-beat data packet (TLAST=1 on the first beat): lock never asserts.
- Downstream stall (TREADY=0 with TVALID=1): load=0, both source readies are 0, and the output holds stable.
- resetn=0 mid-packet: lock, evt_run and evt_forwarded → 0; OUT_TVALID → 0; the partial packet is abandoned. The upstream data source is reset together with this block.

## Timing
- Reset values: AXIS_OUT_TVALID=0, AXIS_OUT_TLAST=0, AXIS_OUT_TDATA=0, evt_forwarded=0, lock=0, evt_run=0.
- Latency: a beat accepted at edge N appears on AXIS_OUT at N+1.
- Throughput: with TREADY held high, one beat per cycle with no bubbles, including across switches between sources.
- Source readies depend combinationally on AXIS_OUT_TREADY, the source TVALIDs and registered state. There is no path from a TREADY output back to the TVALID inputs.
- AXI-Stream rule: once OUT_TVALID=1, OUT_TDATA and OUT_TLAST stay unchanged until the transfer completes.

## Test plan
- **Reset**: hold resetn=0 with both sources valid → both TREADY=0, OUT_TVALID=0, evt_forwarded=0. Release → the first event appears on OUT one cycle later with TLAST=1.
- **No split**: start a 4-beat data packet; assert an event after the 2nd data beat → OUT shows D0,D1,D2,D3(TLAST),E0. The event is held until D3 transfers.
- **Starvation guard**: MAX_EVT_BURST=4; events and one 2-beat data packet both continuously valid → E×4, D0, D1, E×4, repeating. evt_forwarded advances by 4 per round.
- **Backpressure**: toggle OUT_TREADY at random (50%) during mixed traffic → no beat lost or duplicated, OUT_TDATA stable while stalled, output order matches the reference model.
- **Simultaneous start**: event and a 1-beat data packet become valid in the same cycle with evt_run=0 → E then D on consecutive cycles. Afterwards evt_run=0 and lock=0.
- **Counter wrap**: preload evt_forwarded to 0xFFFFFFFE through a force, then send 3 events → evt_forwarded reads 0x00000001.
